// File: rtl/imm_gen_pipe.sv
// Buffered RISC-V immediate generator: decodes I/S/B/U/J immediates at write time into a DEPTH-entry FIFO.
// Optional reserved-format detection enabled by defining IMM_GEN_ILLEGAL_CHECK_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Sign bit of every format is instr[31]; it is folded into the replication.
  function automatic logic signed [XLEN-1:0] decode_imm(input logic [31:0] ins,
                                                       input logic [2:0]  src);
    logic signed [XLEN-1:0] v;
    case (src)
      3'b001:  v = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      3'b010:  v = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b011:  v = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
      3'b100:  v = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: v = {{(XLEN-12){ins[31]}}, ins[31:20]};
    endcase
    return v;
  endfunction

  logic signed [XLEN-1:0]  r_imm_mem [DEPTH];
  logic        [TAG_W-1:0] r_tag_mem [DEPTH];
  logic        [PTR_W-1:0] r_wr_ptr;
  logic        [PTR_W-1:0] r_rd_ptr;
  logic        [CNT_W-1:0] r_count;

  logic                    w_push;
  logic                    w_pop;
  logic signed [XLEN-1:0]  w_dec_imm;

  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

`ifdef IMM_GEN_ILLEGAL_CHECK_EN
  logic r_err_mem [DEPTH];
  logic w_dec_err;

  assign w_dec_err = (imm_src >= 3'b101);
  assign w_dec_imm = w_dec_err ? '0 : decode_imm(instr, imm_src);
  assign err       = out_valid & r_err_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_err_mem[r_wr_ptr] <= w_dec_err;
  end
`else
  assign w_dec_imm = decode_imm(instr, imm_src);
  assign err       = 1'b0;
`endif

  assign imm_ext = out_valid ? r_imm_mem[r_rd_ptr] : '0;
  assign out_tag = out_valid ? r_tag_mem[r_rd_ptr] : '0;

  // Write stage: storage carries no reset, emptiness is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_imm_mem[r_wr_ptr] <= w_dec_imm;
      r_tag_mem[r_wr_ptr] <= in_tag;
    end
  end

  // Control: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus; checked against a queue model.
module tb_imm_gen_pipe;
  localparam int DEPTH = 2;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, out_ready;
  logic [31:0]      instr;
  logic [2:0]       imm_src;
  logic [TAG_W-1:0] in_tag;

  logic             in_ready32, out_valid32, err32;
  logic [31:0]      imm32;
  logic [TAG_W-1:0] tag32;
  logic             in_ready64, out_valid64, err64;
  logic [63:0]      imm64;
  logic [TAG_W-1:0] tag64;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .instr(instr),
    .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .imm_ext(imm32), .out_tag(tag32), .err(err32));

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .instr(instr),
    .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .imm_ext(imm64), .out_tag(tag64), .err(err64));

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } ent_t;

  typedef struct {
    logic [31:0]      instr;
    logic [2:0]       src;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp32;
    logic [63:0]      exp64;
    logic             exp_err;
  } vec_t;

  ent_t mq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Immediate as a signed offset built from field values with shifts.
  function automatic longint ref_imm(input logic [31:0] ins, input logic [2:0] src);
    longint s;
    s = longint'($signed(ins));
    case (src)
      3'd1:    return ((s >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2:    return ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                      (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd3:    return (s >>> 12) <<< 12;
      3'd4:    return ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                      (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      default: return s >>> 20;
    endcase
  endfunction

  function automatic ent_t mk_ent(input logic [31:0] ins, input logic [2:0] src,
                                  input logic [TAG_W-1:0] tg);
    ent_t e;
    e.tag = tg;
    e.imm = 64'(ref_imm(ins, src));
    e.err = 1'b0;
`ifdef IMM_GEN_ILLEGAL_CHECK_EN
    if (src >= 3'd5) begin
      e.imm = '0;
      e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic check_outputs();
    ent_t h;
    logic hv;
    hv = (mq.size() != 0);
    if (hv) h = mq[0];
    else begin
      h.imm = '0; h.tag = '0; h.err = 1'b0;
    end
    check("in_ready32",  64'(in_ready32),  64'(mq.size() != DEPTH));
    check("in_ready64",  64'(in_ready64),  64'(mq.size() != DEPTH));
    check("out_valid32", 64'(out_valid32), 64'(hv));
    check("out_valid64", 64'(out_valid64), 64'(hv));
    check("imm32",       64'(imm32),       64'(h.imm[31:0]));
    check("imm64",       imm64,            h.imm);
    check("tag32",       64'(tag32),       64'(h.tag));
    check("tag64",       64'(tag64),       64'(h.tag));
    check("err32",       64'(err32),       64'(h.err));
    check("err64",       64'(err64),       64'(h.err));
  endtask

  task automatic step();
    bit push, pop;
    push = in_valid && (mq.size() != DEPTH);
    pop  = out_ready && (mq.size() != 0);
    @(posedge clk);
    if (rst) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(mk_ent(instr, imm_src, in_tag));
    end
    #1;
    check_outputs();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'hFFF00093, 3'd0, 5'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[1] = '{32'hFE512E23, 3'd1, 5'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vecs[2] = '{32'hFE000CE3, 3'd2, 5'd3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vecs[3] = '{32'h123450B7, 3'd3, 5'd4, 32'h12345000, 64'h0000000012345000, 1'b0};
    vecs[4] = '{32'h0010006F, 3'd4, 5'd5, 32'h00000800, 64'h0000000000000800, 1'b0};
    vecs[5] = '{32'h800000B7, 3'd3, 5'd6, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
`ifdef IMM_GEN_ILLEGAL_CHECK_EN
    vecs[6] = '{32'hFFF00093, 3'd7, 5'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
`else
    vecs[6] = '{32'hFFF00093, 3'd7, 5'd7, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; imm_src = '0; in_tag = '0;
    step();
    step();
    check("reset_valid", 64'(out_valid32), 64'd0);
    check("reset_ready", 64'(in_ready32), 64'd1);
    rst = 1'b0;

    // Table: with out_ready=1 the head after each edge is the entry just pushed.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; instr = vecs[i].instr; imm_src = vecs[i].src; in_tag = vecs[i].tag;
      step();
      check("vec_imm32", 64'(imm32), 64'(vecs[i].exp32));
      check("vec_imm64", imm64, vecs[i].exp64);
      check("vec_tag",   64'(tag32), 64'(vecs[i].tag));
      check("vec_err",   64'(err32), 64'(vecs[i].exp_err));
    end
    in_valid = 1'b0;
    step();

    // Backpressure: tag 3 must be refused while full.
    out_ready = 1'b0; in_valid = 1'b1; imm_src = 3'd0; instr = 32'h00100093;
    in_tag = 5'd1; step();
    check("bp_ready_after1", 64'(in_ready32), 64'd1);
    in_tag = 5'd2; step();
    check("bp_ready_after2", 64'(in_ready32), 64'd0);
    in_tag = 5'd3; step();
    check("bp_head_tag1", 64'(tag32), 64'd1);
    check("bp_still_full", 64'(in_ready32), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1; step();
    check("bp_head_tag2", 64'(tag32), 64'd2);
    check("bp_ready_back", 64'(in_ready32), 64'd1);
    step();
    check("bp_drained", 64'(out_valid32), 64'd0);

    // Full-rate stream of 8 entries.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_tag = 5'(i + 8); instr = $urandom; imm_src = 3'($urandom_range(0, 4));
      step();
      check("stream_valid", 64'(out_valid32), 64'd1);
      check("stream_tag", 64'(tag64), 64'(i + 8));
    end
    in_valid = 1'b0; step();

    // Reset with two entries queued; push/pop in the reset cycle ignored.
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 5'd20; instr = 32'hFFF00093; imm_src = 3'd0;
    step(); step();
    rst = 1'b1; out_ready = 1'b1; step();
    check("rst_valid", 64'(out_valid64), 64'd0);
    check("rst_imm", imm64, 64'd0);
    check("rst_tag", 64'(tag64), 64'd0);
    check("rst_ready", 64'(in_ready64), 64'd1);
    rst = 1'b0; in_valid = 1'b0; step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      instr     = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      in_tag    = 5'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
